inte: RTL
=========

# inte

Inverse-differencing (integration) stage of the ARIMA datapath. It is the counterpart of the differencing front end: it takes forecasts produced in the d-th-order differenced domain and rebuilds them into the original series domain. It uses a cascade of d running accumulators, seeded from the initial-value snapshot and load pulse that the differencing stage emits. It sits between the ARMA forecast core and the result output.

## Interface
Parameters:
- DW, 32: sample width, signed two's complement.
- MAX_D, 10: maximum supported differencing order. Matches the 0..9 depth of the snapshot array.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- initial_inte  in  MAX_D x DW signed  snapshot from differencing stage. Element k is the latest k-th difference.
- init_inte  in  1  single-cycle load strobe for the snapshot.
- d_order_in  in  32  differencing order. Sampled only on load.
- data_in  in  DW signed  differenced-domain forecast.
- in_valid  in  1  data_in valid.
- in_ready  out  1  stage accepts data_in this cycle.
- data_out  out  DW signed  reconstructed sample.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.
- sample_cnt  out  32  count of accepted samples since the last load.

## Operation
- States:
  - IDLE: after reset.
  - RUN: entered on init_inte.
  - No other states.
- Reset values: state IDLE, all acc[k]=0, d_q=0, data_out=0, out_valid=0, in_ready=0, sample_cnt=0.
- Load (init_inte=1, from any state):
  - d_q = min(d_order_in, MAX_D).
  - acc[k] = initial_inte[k] for k<d_q; acc[k]=0 otherwise.
  - sample_cnt=0; state becomes RUN.
  - out_valid and data_out are left unchanged.
- in_ready = (state==RUN) && !init_inte && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. On accept:
  - new[d_q] = data_in.
  - For k = d_q-1 down to 0: new[k] = acc[k] + new[k+1].
  - acc[k] <= new[k] for k<d_q.
  - data_out <= new[0]; out_valid <= 1; sample_cnt += 1 (wraps at 2^32).
- d_q=0: pass-through, data_out <= data_in, no accumulators updated.
- out_valid clears when out_ready=1 and no accept occurs in the same cycle.
- A simultaneous accept and drain keeps out_valid=1 and puts the new data on data_out.
- Arithmetic is DW-bit; overflow behaviour is set by Configuration.
- An in_valid seen in IDLE is ignored.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 sample/cycle while out_ready=1.
- The accumulator chain is a combinational ripple of up to MAX_D adders inside one cycle. No pipelining.
- init_inte in the same cycle as in_valid: the load wins and the input is not accepted (in_ready=0).
- rst has priority over init_inte and the handshake.
- rst mid-operation returns to IDLE with all values at reset.
- data_out is held stable while out_valid && !out_ready.

## Configuration
- INTE_SAT_EN defined:
  - Every accumulator add saturates to [-2^(DW-1), 2^(DW-1)-1].
  - The saturated value is what is stored in acc and forwarded.
- Undefined: plain two's-complement wrap.

## Structure
- arima_pkg holds:
  - DW and MAX_D as localparams.
  - typedef sample_t (signed [DW-1:0]).
  - typedef state_t enum {IDLE, RUN}.
  - function sat_add(sample_t a, sample_t b), used under INTE_SAT_EN.
- One sub-module: inte_chain, the purely combinational d-stage ripple adder (acc[], data_in, d_q -> new[]). The top holds the FSM, registers and handshake.

## Test plan
- d=1, initial_inte[0]=100, load, then inputs 5, -3, 2 with out_ready=1 -> data_out 105, 102, 104; sample_cnt=3.
- d=2, initial_inte[0]=10, [1]=3, inputs 1, 1 -> data_out 14, 19; acc[1] ends at 5.
- d=0, inputs 7, -9 -> data_out 7, -9, one cycle after each accept.
- Backpressure: out_ready=0 after the first output -> in_ready=0 and data_out holds. Release -> next sample accepted with no loss or duplication.
- d=1, initial_inte[0]=0x7FFFFFF0, input 0x20 -> data_out 0x7FFFFFFF with INTE_SAT_EN; 0x80000010 without.
- Load and reset edge cases:
  - init_inte asserted together with in_valid in RUN -> input not accepted, accumulators reloaded.
  - rst mid-stream -> out_valid=0, in_ready=0, sample_cnt=0 on the next cycle.

Source files
------------

// File: rtl/arima_pkg.sv
// Shared types and constants for the ARIMA datapath: sample type, FSM states,
// and the saturating adder used when INTE_SAT_EN is defined.
package arima_pkg;

    localparam int DW    = 32;
    localparam int MAX_D = 10;
    localparam int DQW   = $clog2(MAX_D + 1);

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    function automatic sample_t sat_add(sample_t a, sample_t b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) begin
            sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat_add = s[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/inte_if.sv
// Stream bus of the integration stage: differenced-domain samples in,
// reconstructed samples out.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. A producer holds valid and data stable until that transfer;
// ready may depend combinationally on the consumer's state and on the
// downstream ready.
interface inte_if;
    import arima_pkg::*;

    sample_t data_in;
    logic    in_valid;
    logic    in_ready;
    sample_t data_out;
    logic    out_valid;
    logic    out_ready;

    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid
    );

    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, out_valid
    );

endinterface

// File: rtl/inte_chain.sv
// Combinational d-stage ripple of running sums. Stage k adds acc[k] to the
// value coming from stage k+1. Adds saturate when INTE_SAT_EN is defined.
module inte_chain
    import arima_pkg::*;
(
    input  sample_t        acc_i [MAX_D],
    input  sample_t        data_i,
    input  logic [DQW-1:0] d_i,
    output sample_t        acc_o [MAX_D],
    output sample_t        y_o
);

    sample_t stage;

    always_comb begin
        stage = data_i;
        for (int k = MAX_D - 1; k >= 0; k--) begin
            acc_o[k] = acc_i[k];
            if (DQW'(k) < d_i) begin
`ifdef INTE_SAT_EN
                stage = sat_add(acc_i[k], stage);
`else
                stage = acc_i[k] + stage;
`endif
                acc_o[k] = stage;
            end
        end
        y_o = stage;
    end

endmodule

// File: rtl/inte.sv
// Inverse-differencing stage: rebuilds original-domain forecasts from
// d-th-order differenced forecasts. INTE_SAT_EN selects saturating adds.
module inte
    import arima_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  sample_t        initial_inte [MAX_D],
    input  logic           init_inte,
    input  logic [31:0]    d_order_in,
    output logic [31:0]    sample_cnt,
    inte_if.slave          bus,
    output state_t         dbg_state,
    output sample_t        dbg_acc [MAX_D]
);

    state_t         state_q, state_d;
    logic [DQW-1:0] d_q, d_d;
    sample_t        acc_q [MAX_D];
    sample_t        acc_d [MAX_D];
    sample_t        data_out_q, data_out_d;
    logic           out_valid_q, out_valid_d;
    logic [31:0]    cnt_q, cnt_d;

    sample_t        acc_new [MAX_D];
    sample_t        y_new;
    logic [DQW-1:0] d_load;
    logic           in_ready;
    logic           accept;

    // Orders above MAX_D clamp rather than truncate to the register width.
    assign d_load = (d_order_in > 32'(MAX_D)) ? DQW'(MAX_D) : d_order_in[DQW-1:0];

    assign in_ready = (state_q == RUN) && !init_inte && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    inte_chain u_chain (
        .acc_i  (acc_q),
        .data_i (bus.data_in),
        .d_i    (d_q),
        .acc_o  (acc_new),
        .y_o    (y_new)
    );

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        acc_d       = acc_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (bus.out_ready) out_valid_d = 1'b0;

        if (init_inte) begin
            state_d = RUN;
            d_d     = d_load;
            for (int k = 0; k < MAX_D; k++) begin
                acc_d[k] = (DQW'(k) < d_load) ? initial_inte[k] : '0;
            end
            cnt_d = '0;
        end else if (accept) begin
            acc_d       = acc_new;
            data_out_d  = y_new;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            for (int k = 0; k < MAX_D; k++) acc_q[k] <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign sample_cnt    = cnt_q;
    assign dbg_state     = state_q;
    assign dbg_acc       = acc_q;

endmodule
